// File: rtl/reorder_buffer_nway_if.sv
// Dispatch / completion / retire / restore bundle for reorder_buffer_nway.
// master = core side, slave = ROB.
interface reorder_buffer_nway_if #(
  parameter int unsigned N       = 3,
  parameter int unsigned C       = 3,
  parameter int unsigned ENTRY_W = 64,
  parameter int unsigned IDX_W   = 5,
  parameter int unsigned CNT_W   = 2
);
  logic [N*ENTRY_W-1:0] disp_entries;
  logic [CNT_W-1:0]     disp_valid;
  logic [CNT_W-1:0]     rob_spots;
  logic [IDX_W-1:0]     rob_tail;
  logic [C-1:0]         cmpl_valid;
  logic [C*IDX_W-1:0]   cmpl_idx;
  logic [CNT_W-1:0]     num_retiring;
  logic [N*ENTRY_W-1:0] head_entries;
  logic [N-1:0]         head_complete;
  logic [CNT_W-1:0]     head_valid;
  logic [IDX_W-1:0]     head_idx;
  logic                 tail_restore_valid;
  logic [IDX_W-1:0]     tail_restore;

  modport master (
    output disp_entries, disp_valid, cmpl_valid, cmpl_idx, num_retiring,
           tail_restore_valid, tail_restore,
    input  rob_spots, rob_tail, head_entries, head_complete, head_valid, head_idx
  );

  modport slave (
    input  disp_entries, disp_valid, cmpl_valid, cmpl_idx, num_retiring,
           tail_restore_valid, tail_restore,
    output rob_spots, rob_tail, head_entries, head_complete, head_valid, head_idx
  );
endinterface

// File: rtl/reorder_buffer_nway.sv
// N-wide circular reorder buffer with C completion ports and single-cycle tail restore.
// Define ROB_ASSERT_EN to enable in-module caller-obligation assertions.
module reorder_buffer_nway #(
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned N       = 3,
  parameter int unsigned C       = 3,
  parameter int unsigned ENTRY_W = 64,
  parameter int unsigned IDX_W   = $clog2(DEPTH),
  parameter int unsigned CNT_W   = $clog2(N+1)
) (
  input logic                  clock,
  input logic                  reset,
  reorder_buffer_nway_if.slave rob
);
  localparam int unsigned NUM_W = $clog2(DEPTH+1);

  logic [IDX_W-1:0]   head_q, head_d;
  logic [IDX_W-1:0]   tail_q, tail_d;
  logic [NUM_W-1:0]   num_q, num_d;
  logic [DEPTH-1:0]   cmpl_q, cmpl_d;
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [NUM_W-1:0]   free_w;
  logic               dispatch_en;

  always_comb begin
    free_w            = NUM_W'(DEPTH) - num_q;
    rob.rob_spots     = (free_w >= NUM_W'(N)) ? CNT_W'(N) : CNT_W'(free_w);
    rob.head_valid    = (num_q >= NUM_W'(N)) ? CNT_W'(N) : CNT_W'(num_q);
    rob.head_idx      = head_q;
    rob.rob_tail      = tail_q;
    rob.head_entries  = '0;
    rob.head_complete = '0;
    for (int unsigned i = 0; i < N; i++) begin
      rob.head_entries[i*ENTRY_W +: ENTRY_W] = mem_q[head_q + IDX_W'(i)];
      rob.head_complete[i]                   = cmpl_q[head_q + IDX_W'(i)];
    end
  end

  always_comb begin
    dispatch_en = !rob.tail_restore_valid;
    head_d      = head_q + IDX_W'(rob.num_retiring);
    if (rob.tail_restore_valid) begin
      tail_d = rob.tail_restore;
      num_d  = NUM_W'(IDX_W'(rob.tail_restore - head_d));
    end else begin
      tail_d = tail_q + IDX_W'(rob.disp_valid);
      num_d  = num_q + NUM_W'(rob.disp_valid) - NUM_W'(rob.num_retiring);
    end
    // Completions first so a same-cycle dispatch to the slot clears it last.
    cmpl_d = cmpl_q;
    for (int unsigned c = 0; c < C; c++) begin
      if (rob.cmpl_valid[c]) cmpl_d[rob.cmpl_idx[c*IDX_W +: IDX_W]] = 1'b1;
    end
    if (dispatch_en) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (i < 32'(rob.disp_valid)) cmpl_d[tail_q + IDX_W'(i)] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      num_q  <= '0;
      cmpl_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      num_q  <= num_d;
      cmpl_q <= cmpl_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && dispatch_en) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (i < 32'(rob.disp_valid))
          mem_q[tail_q + IDX_W'(i)] <= rob.disp_entries[i*ENTRY_W +: ENTRY_W];
      end
    end
  end

`ifdef ROB_ASSERT_EN
  logic [NUM_W-1:0] occ_chk;
  logic [NUM_W-1:0] free_chk;
  logic [CNT_W-1:0] spots_chk;

  always_comb begin
    occ_chk   = (tail_q == head_q && num_q != '0) ? NUM_W'(DEPTH)
                                                  : NUM_W'(IDX_W'(tail_q - head_q));
    free_chk  = NUM_W'(DEPTH) - occ_chk;
    spots_chk = (free_chk >= NUM_W'(N)) ? CNT_W'(N) : CNT_W'(free_chk);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (32'(rob.disp_valid) <= N)
        else begin $error("disp_valid exceeds N"); $finish; end
      assert (32'(rob.disp_valid) <= 32'(rob.rob_spots) + 32'(rob.num_retiring))
        else begin $error("disp_valid exceeds free space"); $finish; end
      assert (rob.num_retiring <= rob.head_valid)
        else begin $error("num_retiring exceeds head_valid"); $finish; end
      assert (!rob.tail_restore_valid ||
              NUM_W'(IDX_W'(rob.tail_restore - head_d)) <= num_q - NUM_W'(rob.num_retiring))
        else begin $error("tail_restore outside live window"); $finish; end
      assert (rob.rob_spots == spots_chk)
        else begin $error("rob_spots inconsistent with head/tail"); $finish; end
    end
  end
`else
  // No run-time obligation checks in this build.
`endif
endmodule

// File: tb/tb_reorder_buffer_nway.sv
// Randomised bench for reorder_buffer_nway against an age-ordered queue model,
// preceded by directed steps with hand-computed expectations.
module tb_reorder_buffer_nway;
  localparam int D  = 8;
  localparam int N  = 3;
  localparam int C  = 3;
  localparam int EW = 16;
  localparam int IW = 3;
  localparam int CW = 2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  reorder_buffer_nway_if #(.N(N), .C(C), .ENTRY_W(EW), .IDX_W(IW), .CNT_W(CW)) rif ();

  reorder_buffer_nway #(.DEPTH(D), .N(N), .C(C), .ENTRY_W(EW), .IDX_W(IW), .CNT_W(CW)) dut (
    .clock(clock),
    .reset(reset),
    .rob  (rif)
  );

  int checks   = 0;
  int failures = 0;

  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endfunction

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  typedef struct {
    logic [EW-1:0] pay;
    bit            done;
  } ent_t;

  ent_t mq[$];   // live entries, oldest first
  int   mhead;
  bit   chk_en = 1'b0;

  int            s_disp, s_ret, s_rt;
  logic [EW-1:0] s_pay [N];
  bit            s_cv  [C];
  int            s_ci  [C];
  bit            s_rst, s_rv;

  task automatic set_idle();
    s_disp = 0; s_ret = 0; s_rst = 1'b0; s_rv = 1'b0; s_rt = 0;
    for (int i = 0; i < N; i++) s_pay[i] = '0;
    for (int c = 0; c < C; c++) begin s_cv[c] = 1'b0; s_ci[c] = 0; end
  endtask

  task automatic set_disp(int n, int base);
    s_disp = n;
    for (int i = 0; i < N; i++) s_pay[i] = EW'(base + i);
  endtask

  task automatic model_update();
    int nh, sz, k, keep;
    if (s_rst) begin
      mq.delete();
      mhead = 0;
      return;
    end
    nh = (mhead + s_ret) % D;
    sz = mq.size();
    for (int c = 0; c < C; c++) begin
      if (s_cv[c]) begin
        k = (s_ci[c] - mhead + D) % D;
        if (k < sz) mq[k].done = 1'b1;
      end
    end
    repeat (s_ret) void'(mq.pop_front());
    if (s_rv) begin
      keep = (s_rt - nh + D) % D;
      while (mq.size() > keep) void'(mq.pop_back());
    end else begin
      for (int i = 0; i < s_disp; i++) mq.push_back('{pay: s_pay[i], done: 1'b0});
    end
    mhead = nh;
  endtask

  task automatic step();
    #1;
    reset                  = s_rst;
    rif.disp_valid         = CW'(s_disp);
    rif.num_retiring       = CW'(s_ret);
    rif.tail_restore_valid = s_rv;
    rif.tail_restore       = IW'(s_rt);
    for (int i = 0; i < N; i++) rif.disp_entries[i*EW +: EW] = s_pay[i];
    for (int c = 0; c < C; c++) begin
      rif.cmpl_valid[c]          = s_cv[c];
      rif.cmpl_idx[c*IW +: IW]   = IW'(s_ci[c]);
    end
    @(posedge clock);
    model_update();
    @(negedge clock);
  endtask

  always @(negedge clock) begin : cmp
    int sz, hv;
    if (chk_en) begin
      sz = mq.size();
      hv = imin(N, sz);
      chk("rob_spots",  rif.rob_spots,  imin(N, D - sz));
      chk("head_valid", rif.head_valid, hv);
      chk("head_idx",   rif.head_idx,   mhead);
      chk("rob_tail",   rif.rob_tail,   (mhead + sz) % D);
      for (int i = 0; i < hv; i++) begin
        chk("head_entry",    rif.head_entries[i*EW +: EW], mq[i].pay);
        chk("head_complete", rif.head_complete[i],         mq[i].done);
      end
    end
  end

  initial begin
    int sz, maxd, nh, k;
    set_idle();
    @(negedge clock);

    // Reset held two cycles
    s_rst = 1'b1;
    step(); step();
    s_rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_spots",    rif.rob_spots,     3);
    chk("rst_hvalid",   rif.head_valid,    0);
    chk("rst_tail",     rif.rob_tail,      0);
    chk("rst_head",     rif.head_idx,      0);
    chk("rst_complete", rif.head_complete, 0);

    // Fill with 0..7 as 3,3,2
    set_idle(); set_disp(3, 0); step();
    set_disp(3, 3); step();
    set_disp(2, 6); step();
    chk("full_spots",  rif.rob_spots,  0);
    chk("full_hvalid", rif.head_valid, 3);
    chk("full_tail",   rif.rob_tail,   0);
    chk("full_e0", rif.head_entries[0*EW +: EW], 0);
    chk("full_e1", rif.head_entries[1*EW +: EW], 1);
    chk("full_e2", rif.head_entries[2*EW +: EW], 2);

    // Retire 3 and dispatch 3 while full
    set_idle(); s_ret = 3; set_disp(3, 8); step();
    chk("rd_head",  rif.head_idx,  3);
    chk("rd_tail",  rif.rob_tail,  3);
    chk("rd_spots", rif.rob_spots, 0);
    chk("rd_e0", rif.head_entries[0*EW +: EW], 3);
    chk("rd_e1", rif.head_entries[1*EW +: EW], 4);
    chk("rd_e2", rif.head_entries[2*EW +: EW], 5);

    // Duplicate completion to idx 4 on two ports
    set_idle(); s_cv[0] = 1'b1; s_cv[1] = 1'b1; s_ci[0] = 4; s_ci[1] = 4; step();
    chk("dup_complete", rif.head_complete, 3'b010);

    // Dispatch into 3..5 with a same-cycle completion to 4: dispatch wins
    set_idle(); s_ret = 3; set_disp(3, 11); s_cv[0] = 1'b1; s_ci[0] = 4; step();
    set_idle(); s_ret = 3; step();
    chk("wrap_head", rif.head_idx, 1);
    chk("wrap_e0", rif.head_entries[0*EW +: EW], 9);
    chk("wrap_e1", rif.head_entries[1*EW +: EW], 10);
    chk("wrap_e2", rif.head_entries[2*EW +: EW], 11);
    set_idle(); s_ret = 3; step();
    chk("dw_hvalid", rif.head_valid, 2);
    chk("dw_e0", rif.head_entries[0*EW +: EW], 12);
    chk("dw_cmpl0", rif.head_complete[0], 0);

    // Tail restore: head 0, tail 6 -> restore to 2 with one retire
    set_idle(); s_rst = 1'b1; step();
    set_idle(); set_disp(3, 20); step();
    set_disp(3, 23); step();
    set_idle(); s_rv = 1'b1; s_rt = 2; set_disp(2, 40); s_ret = 1; step();
    chk("rs_head",   rif.head_idx,   1);
    chk("rs_tail",   rif.rob_tail,   2);
    chk("rs_hvalid", rif.head_valid, 1);
    chk("rs_spots",  rif.rob_spots,  3);
    chk("rs_e0", rif.head_entries[0*EW +: EW], 21);

    // Reset while full with retire, dispatch and completions pending
    set_idle(); set_disp(3, 50); step();
    set_disp(3, 53); step();
    set_disp(1, 56); step();
    chk("pre_rst_spots", rif.rob_spots, 0);
    set_idle(); s_rst = 1'b1; s_ret = 2; set_disp(2, 60);
    for (int c = 0; c < C; c++) begin s_cv[c] = 1'b1; s_ci[c] = c + 1; end
    step();
    chk("mid_rst_spots",    rif.rob_spots,     3);
    chk("mid_rst_hvalid",   rif.head_valid,    0);
    chk("mid_rst_tail",     rif.rob_tail,      0);
    chk("mid_rst_head",     rif.head_idx,      0);
    chk("mid_rst_complete", rif.head_complete, 0);

    // Randomised traffic within caller obligations
    for (int cyc = 0; cyc < 3000; cyc++) begin
      set_idle();
      sz     = mq.size();
      s_rst  = ($urandom_range(299) == 0);
      s_ret  = $urandom_range(imin(N, sz));
      maxd   = imin(N, D - sz + s_ret);
      s_disp = ($urandom_range(3) == 0) ? $urandom_range(maxd) : maxd;
      for (int i = 0; i < N; i++) s_pay[i] = EW'($urandom);
      for (int c = 0; c < C; c++) begin
        s_cv[c] = $urandom_range(1);
        s_ci[c] = $urandom_range(D - 1);
      end
      s_rv = ($urandom_range(7) == 0);
      if (s_rv) begin
        nh   = (mhead + s_ret) % D;
        k    = $urandom_range(imin(sz - s_ret, D - 1));
        s_rt = (nh + k) % D;
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reorder_buffer_nway.md
Name: reorder_buffer_nway

Overview:
- Parametrised circular reorder buffer (ROB) between Dispatch, the complete/CDB stage and Retire in the R10k-style OoO core.
- Accepts up to N in-order instructions per cycle at the tail.
- Records completion from C writeback ports.
- Presents the oldest N entries, with complete flags, to Retire, and frees up to N per cycle.
- Supports single-cycle tail restore on branch mispredict.

Parameters:
DEPTH, 32, number of ROB entries; power of two, >= 2*N
N, 3, superscalar width for dispatch, head view and retire
C, 3, number of completion (CDB) ports
ENTRY_W, 64, bits of opaque payload per entry
IDX_W, $clog2(DEPTH), ROB index width
CNT_W, $clog2(N+1), per-cycle count width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
disp_entries  in  N*ENTRY_W  payloads, slot 0 oldest
disp_valid  in  CNT_W  number of valid dispatch slots (contiguous from slot 0)
rob_spots  out  CNT_W  min(N, DEPTH - num_entries)
rob_tail  out  IDX_W  index that disp slot 0 will receive; slot i gets (rob_tail+i) mod DEPTH
cmpl_valid  in  C  completion strobe per port
cmpl_idx  in  C*IDX_W  ROB index being completed
num_retiring  in  CNT_W  head entries freed this cycle
head_entries  out  N*ENTRY_W  payloads at head+i
head_complete  out  N  complete flag at head+i
head_valid  out  CNT_W  min(N, num_entries)
head_idx  out  IDX_W  current head index
tail_restore_valid  in  1  mispredict squash request
tail_restore  in  IDX_W  checkpointed tail to restore

Behaviour:
- State: head, tail (IDX_W); num_entries (CLOG2(DEPTH+1) bits); payload RAM and complete bit per entry. num_entries disambiguates full from empty when head==tail.
- Reset: head=0, tail=0, num_entries=0, all complete bits 0. Resulting outputs: rob_spots=N, head_valid=0, rob_tail=0, head_idx=0, head_complete=0.
- Outputs are combinational from registered state. Latency:
  - Dispatch is visible at the head one cycle later.
  - Completion is visible in head_complete one cycle later.
- Dispatch: disp_valid <= min(N, DEPTH - num_entries + num_retiring) is a caller obligation. Space freed by a same-cycle retire is usable.
  - Each accepted slot writes its payload and clears its complete bit.
  - tail' = (tail + disp_valid) mod DEPTH.
- Retire: num_retiring <= head_valid is a caller obligation. head' = (head + num_retiring) mod DEPTH. Freed entries' complete bits are don't-care.
- Count: num_entries' = num_entries + disp_valid - num_retiring, with all terms widened before the arithmetic.
- Completion: for each port with cmpl_valid, set complete[cmpl_idx].
  - Duplicate indices across ports are legal; the result is idempotent.
  - Completion to a slot being dispatched in the same cycle: dispatch wins and the bit is cleared.
- Tail restore: when tail_restore_valid=1:
  - Dispatch that cycle is ignored.
  - Retire is still applied.
  - Completions are still applied.
  - tail' = tail_restore.
  - num_entries' = (tail_restore - head') mod DEPTH. tail_restore==head' yields empty; a full ROB is never restored to.
  - tail_restore must lie in [head', tail] circularly (caller obligation).
- Wrap-around: every index uses mod DEPTH arithmetic. head_entries and slot writes cross index DEPTH-1 -> 0 seamlessly.
- Boundaries:
  - Full: rob_spots=0, and dispatch is accepted only up to num_retiring.
  - Empty: head_valid=0, and num_retiring must be 0.
  - Reset asserted mid-operation overrides dispatch, retire, completion and restore in that cycle.

Optional Feature:
Macro ROB_ASSERT_EN.
- Defined: in-module immediate assertions ($error then $finish), disabled while reset is high. They check:
  - disp_valid <= N;
  - disp_valid <= rob_spots + num_retiring;
  - num_retiring <= head_valid;
  - tail_restore lies within the live window;
  - rob_spots == min(N, DEPTH - ((tail - head) mod DEPTH)), or 0 when full.
- Undefined: no assertions. Functional behaviour is identical in both builds.

Test Plan:
1. DEPTH=8, N=3. Hold reset 2 cycles -> rob_spots=3, head_valid=0, rob_tail=0, head_idx=0, head_complete=000.
2. Dispatch payloads 0..7 as 3, 3, 2 over three cycles -> num_entries=8, rob_spots=0, head_entries=0,1,2, head_valid=3, rob_tail=0.
3. From full, num_retiring=3 with disp_valid=3 (payloads 8,9,10) in the same cycle -> head_idx=3, rob_tail=3, rob_spots=0, head_entries=3,4,5; entries 0..2 hold 8..10.
4. cmpl_valid=3'b011 with both ports at cmpl_idx=4 -> next cycle head_complete[1]=1, others 0.
   - Then dispatch into idx 4 with a same-cycle completion to idx 4 -> bit stays 0.
5. head=0, tail=6; tail_restore_valid=1, tail_restore=2, disp_valid=2, num_retiring=1 -> head_idx=1, rob_tail=2, head_valid=1, rob_spots=3, dispatch dropped.
6. Reset asserted while full with completions pending -> next cycle all state is at reset values.
